// File: rtl/envelope_shaper.sv
// ADSR amplitude envelope applied to the harmonic sample stream.
// The envelope steps only on sample ticks; each tick also emits one shaped sample a cycle later.
module envelope_shaper #(
  parameter logic [15:0] ATTACK_STEP  = 16'd137,
  parameter logic [15:0] DECAY_STEP   = 16'd27,
  parameter logic [15:0] RELEASE_STEP = 16'd14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               note_start,
  input  logic               note_held,
  input  logic [15:0]        sustain_level,
  input  logic signed [17:0] sample_in,
  input  logic               sample_in_ready,
  output logic signed [17:0] sample_out,
  output logic               sample_out_ready,
  output logic [15:0]        env_level,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] env_reg, env_next;

  // One extra bit on each step result exposes overflow/borrow for the clamps.
  logic [16:0] attack_sum;
  logic [16:0] decay_diff;
  logic [16:0] release_diff;

  assign attack_sum   = {1'b0, env_reg} + {1'b0, ATTACK_STEP};
  assign decay_diff   = {1'b0, env_reg} - {1'b0, DECAY_STEP};
  assign release_diff = {1'b0, env_reg} - {1'b0, RELEASE_STEP};

  // Envelope is treated as a non-negative Q0.16 gain, so it gets a zero sign bit.
  logic signed [34:0] product;
  assign product = 35'(sample_in) * 35'($signed({1'b0, env_reg}));

  always_comb begin
    state_next = state_reg;
    env_next   = env_reg;
    if (note_start) begin
      // Retrigger keeps the current level so the restart is click-free.
      state_next = ATTACK;
    end else if (sample_in_ready) begin
      case (state_reg)
        IDLE: begin
          env_next = '0;
        end
        ATTACK: begin
          if (!note_held) begin
            state_next = RELEASE;
          end else if (attack_sum[16] || (attack_sum[15:0] == 16'hFFFF)) begin
            env_next   = 16'hFFFF;
            state_next = DECAY;
          end else begin
            env_next = attack_sum[15:0];
          end
        end
        DECAY: begin
          if (!note_held) begin
            state_next = RELEASE;
          end else if (decay_diff[16] || (decay_diff[15:0] <= sustain_level)) begin
            env_next   = sustain_level;
            state_next = SUSTAIN;
          end else begin
            env_next = decay_diff[15:0];
          end
        end
        SUSTAIN: begin
          if (!note_held) begin
            state_next = RELEASE;
          end else begin
            env_next = sustain_level;
          end
        end
        RELEASE: begin
          if (release_diff[16] || (release_diff[15:0] == 16'h0000)) begin
            env_next   = '0;
            state_next = IDLE;
          end else begin
            env_next = release_diff[15:0];
          end
        end
        default: begin
          env_next   = '0;
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      env_reg          <= '0;
      sample_out       <= '0;
      sample_out_ready <= 1'b0;
    end else begin
      state_reg        <= state_next;
      env_reg          <= env_next;
      sample_out_ready <= sample_in_ready;
      if (sample_in_ready) begin
        // Product uses the pre-update envelope; floor shift keeps |out| <= |in|.
        sample_out <= 18'(product >>> 16);
      end
    end
  end

  assign env_level = env_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_envelope_shaper.sv
// Bench for envelope_shaper: two instances (test-plan steps and default steps) driven
// by the same stimulus, checked every cycle against an arithmetic ADSR model.
module tb_envelope_shaper;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               note_start = 1'b0;
  logic               note_held = 1'b0;
  logic [15:0]        sustain_level = 16'h0000;
  logic signed [17:0] sample_in = '0;
  logic               sample_in_ready = 1'b0;

  logic signed [17:0] so0, so1;
  logic               rdy0, rdy1;
  logic [15:0]        env0, env1;
  logic               busy0, busy1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  envelope_shaper #(
    .ATTACK_STEP (16'h4000),
    .DECAY_STEP  (16'h2000),
    .RELEASE_STEP(16'h3000)
  ) dut0 (
    .clk(clk), .reset(reset), .note_start(note_start), .note_held(note_held),
    .sustain_level(sustain_level), .sample_in(sample_in), .sample_in_ready(sample_in_ready),
    .sample_out(so0), .sample_out_ready(rdy0), .env_level(env0), .busy(busy0)
  );

  envelope_shaper dut1 (
    .clk(clk), .reset(reset), .note_start(note_start), .note_held(note_held),
    .sustain_level(sustain_level), .sample_in(sample_in), .sample_in_ready(sample_in_ready),
    .sample_out(so1), .sample_out_ready(rdy1), .env_level(env1), .busy(busy1)
  );

  // ---------------- behavioural model ----------------
  localparam int S_IDLE = 0, S_ATTACK = 1, S_DECAY = 2, S_SUSTAIN = 3, S_RELEASE = 4;
  int p_attack[2]  = '{'h4000, 137};
  int p_decay[2]   = '{'h2000, 27};
  int p_release[2] = '{'h3000, 14};

  int m_st[2];
  int m_env[2];
  int m_out[2];
  bit m_rdy[2];
  bit model_valid = 1'b0;

  function automatic int floor_div_65536(longint p);
    longint q;
    q = p / 64'sd65536;
    if (p < 0 && (p % 64'sd65536) != 0) q = q - 1;
    return int'(q);
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_st[i] = S_IDLE; m_env[i] = 0; m_out[i] = 0; m_rdy[i] = 1'b0;
      end else begin
        m_rdy[i] = sample_in_ready;
        if (sample_in_ready)
          m_out[i] = floor_div_65536(longint'(sample_in) * longint'(m_env[i]));
        if (note_start) begin
          m_st[i] = S_ATTACK;
        end else if (sample_in_ready) begin
          if (!note_held && (m_st[i] == S_ATTACK || m_st[i] == S_DECAY || m_st[i] == S_SUSTAIN)) begin
            m_st[i] = S_RELEASE;
          end else begin
            case (m_st[i])
              S_IDLE: m_env[i] = 0;
              S_ATTACK: begin
                m_env[i] = imin(m_env[i] + p_attack[i], 65535);
                if (m_env[i] == 65535) m_st[i] = S_DECAY;
              end
              S_DECAY: begin
                m_env[i] = imax(m_env[i] - p_decay[i], int'(sustain_level));
                if (m_env[i] == int'(sustain_level)) m_st[i] = S_SUSTAIN;
              end
              S_SUSTAIN: m_env[i] = int'(sustain_level);
              default: begin
                m_env[i] = imax(m_env[i] - p_release[i], 0);
                if (m_env[i] == 0) m_st[i] = S_IDLE;
              end
            endcase
          end
        end
      end
    end
    if (reset) model_valid = 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp(input string name, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t actual=%0d (0x%0h) required=%0d (0x%0h)",
               name, inst, $time, act, act, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      cmp("model_sample_out", 0, int'(so0), m_out[0]);
      cmp("model_ready",      0, int'(rdy0), int'(m_rdy[0]));
      cmp("model_env",        0, int'(env0), m_env[0]);
      cmp("model_busy",       0, int'(busy0), int'(m_st[0] != S_IDLE));
      cmp("model_sample_out", 1, int'(so1), m_out[1]);
      cmp("model_ready",      1, int'(rdy1), int'(m_rdy[1]));
      cmp("model_env",        1, int'(env1), m_env[1]);
      cmp("model_busy",       1, int'(busy1), int'(m_st[1] != S_IDLE));
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic do_tick();
    sample_in_ready = 1'b1;
    @(negedge clk);
    sample_in_ready = 1'b0;
  endtask

  task automatic pulse_start();
    note_start = 1'b1;
    @(negedge clk);
    note_start = 1'b0;
  endtask

  int exp1[10] = '{'h0, 'h4000, 'h8000, 'hC000, 'hFFFF, 'hDFFF, 'hBFFF, 'h9FFF, 'h8000, 'h8000};
  int rel_env[5] = '{'h8000, 'h5000, 'h2000, 'h0, 'h0};
  int rel_out[5] = '{'h8000, 'h8000, 'h5000, 'h2000, 'h0};

  initial begin
    repeat (2) @(negedge clk);
    cmp("lit_reset_env", 0, int'(env0), 0);
    cmp("lit_reset_out", 0, int'(so0), 0);
    cmp("lit_reset_busy", 0, int'(busy0), 0);
    reset = 1'b0;

    // Attack/decay/sustain with a full-scale-ish input.
    note_held = 1'b1; sustain_level = 16'h8000; sample_in = 18'sd65536;
    pulse_start();
    cmp("lit_start_busy", 0, int'(busy0), 1);
    for (int k = 0; k < 10; k++) begin
      do_tick();
      cmp("lit_p1_out", 0, int'(so0), exp1[k]);
      cmp("lit_p1_rdy_hi", 0, int'(rdy0), 1);
      @(negedge clk);
      cmp("lit_p1_rdy_lo", 0, int'(rdy0), 0);
      repeat (2) @(negedge clk);
    end

    // Release down to idle.
    note_held = 1'b0;
    for (int k = 0; k < 5; k++) begin
      do_tick();
      cmp("lit_p2_env", 0, int'(env0), rel_env[k]);
      cmp("lit_p2_out", 0, int'(so0), rel_out[k]);
      cmp("lit_p2_busy", 0, int'(busy0), (k >= 3) ? 0 : 1);
      repeat (3) @(negedge clk);
    end

    // Retrigger during release at 0x5000.
    note_held = 1'b1;
    pulse_start();
    for (int k = 0; k < 8; k++) do_tick();
    cmp("lit_p3_sustain", 0, int'(env0), 'h8000);
    note_held = 1'b0;
    do_tick();
    do_tick();
    cmp("lit_p3_rel", 0, int'(env0), 'h5000);
    note_held = 1'b1;
    pulse_start();
    cmp("lit_p3_keep", 0, int'(env0), 'h5000);
    do_tick();
    cmp("lit_p3_step", 0, int'(env0), 'h9000);
    cmp("lit_p3_out", 0, int'(so0), 'h5000);

    // note_start, tick and released key in one cycle.
    note_start = 1'b1; sample_in_ready = 1'b1; note_held = 1'b0;
    @(negedge clk);
    note_start = 1'b0; sample_in_ready = 1'b0; note_held = 1'b1;
    cmp("lit_p4_out", 0, int'(so0), 'h9000);
    cmp("lit_p4_env", 0, int'(env0), 'h9000);
    do_tick();
    cmp("lit_p4_attack", 0, int'(env0), 'hD000);

    // Sign and floor behaviour at env = 0x8000.
    for (int k = 0; k < 5; k++) do_tick();
    cmp("lit_p5_env", 0, int'(env0), 'h8000);
    sample_in = -18'sd3;      do_tick(); cmp("lit_p5_neg3", 0, int'(so0), -2);
    sample_in = -18'sd131072; do_tick(); cmp("lit_p5_min", 0, int'(so0), -65536);
    sample_in = 18'sd131071;  do_tick(); cmp("lit_p5_max", 0, int'(so0), 65535);

    // Reset mid-attack with a simultaneous tick.
    pulse_start();
    do_tick();
    reset = 1'b1; sample_in_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0; sample_in_ready = 1'b0;
    cmp("lit_p6_env", 0, int'(env0), 0);
    cmp("lit_p6_busy", 0, int'(busy0), 0);
    cmp("lit_p6_out", 0, int'(so0), 0);
    cmp("lit_p6_rdy", 0, int'(rdy0), 0);

    // Random phase: sparse note events, slow key changes, mixed tick spacing.
    for (int c = 0; c < 12000; c++) begin
      reset = ($urandom_range(0, 999) == 0);
      note_start = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 249) == 0) note_held = ~note_held;
      if ($urandom_range(0, 399) == 0) begin
        case ($urandom_range(0, 3))
          0: sustain_level = 16'h0000;
          1: sustain_level = 16'hFFFF;
          default: sustain_level = 16'($urandom);
        endcase
      end
      sample_in_ready = ($urandom_range(0, 2) == 0);
      sample_in = 18'($urandom);
      @(negedge clk);
    end
    reset = 1'b0; note_start = 1'b0; sample_in_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
